us_distance_poller: RTL

US_DISTANCE_POLLER -- requirements
Module: us_distance_poller

---
 rtl/us_distance_poller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/us_distance_poller.sv
// Polls an ultrasonic sensor's ready bit, reads the echo count on each
// ready rising edge, converts it to cm and keeps a 4-sample average.
module us_distance_poller #(
   parameter int unsigned CYCLES_PER_CM = 2900,
   parameter int unsigned MAX_CM        = 400,
   parameter int unsigned NEAR_CM       = 20,
   parameter int unsigned HYST_CM       = 5
) (
   input  logic        clk,
   input  logic        reset_all,
   output logic        us_addr,
   output logic        us_read_en,
   output logic        us_write_en,
   output logic [31:0] us_write_data,
   input  logic [31:0] us_read_data,
   output logic [15:0] dist_cm,
   output logic [15:0] dist_avg_cm,
   output logic        dist_valid,
   output logic        out_of_range,
   output logic        near
);

   localparam logic [31:0] DIV_C   = 32'(CYCLES_PER_CM);
   localparam logic [31:0] MAX_C   = 32'(MAX_CM);
   localparam logic [15:0] NEAR_LO = 16'(NEAR_CM);
   localparam logic [15:0] NEAR_HI = 16'(NEAR_CM + HYST_CM);

   typedef enum logic [2:0] {
      RDY_REQ, RDY_CHK, CNT_REQ, CNT_CAP, DIV, UPDATE
   } state_t;

   state_t      state, state_nxt;
   logic        prev_rdy;
   logic        rdy;
   logic [31:0] count_reg;
   logic [31:0] rem;
   logic [4:0]  bit_cnt;
   logic [15:0] win [4];
   logic [17:0] sum;

   logic [32:0] rem_sh;
   logic        rem_ge;
   logic [31:0] rem_sub;
   logic        over;
   logic [15:0] new_cm;
   logic [17:0] sum_nxt;
   logic [15:0] avg_nxt;
   logic        addr_nxt;
   logic        rd_en_nxt;

   assign us_write_en   = 1'b0;
   assign us_write_data = 32'd0;
   assign rdy           = us_read_data[0];

   // Restoring divide step: the quotient shifts into count_reg from the right
   assign rem_sh  = {rem, count_reg[31]};
   assign rem_ge  = rem_sh >= {1'b0, DIV_C};
   assign rem_sub = rem_sh[31:0] - DIV_C;

   assign over    = count_reg > MAX_C;
   assign new_cm  = over ? MAX_C[15:0] : count_reg[15:0];
   assign sum_nxt = sum - {2'b00, win[3]} + {2'b00, new_cm};
   assign avg_nxt = sum_nxt[17:2];

   always_comb begin
      state_nxt = state;
      unique case (state)
         RDY_REQ: state_nxt = RDY_CHK;
         RDY_CHK: state_nxt = (!prev_rdy && rdy) ? CNT_REQ : RDY_REQ;
         CNT_REQ: state_nxt = CNT_CAP;
         CNT_CAP: state_nxt = DIV;
         DIV:     state_nxt = (bit_cnt == 5'd31) ? UPDATE : DIV;
         UPDATE:  state_nxt = RDY_REQ;
         default: state_nxt = RDY_REQ;
      endcase
   end

   // Sensor strobes are registered from the state being entered
   always_comb begin
      addr_nxt  = us_addr;
      rd_en_nxt = 1'b0;
      unique case (state_nxt)
         RDY_REQ, RDY_CHK: begin
            addr_nxt  = 1'b0;
            rd_en_nxt = 1'b1;
         end
         CNT_REQ: begin
            addr_nxt  = 1'b1;
            rd_en_nxt = 1'b1;
         end
         CNT_CAP: addr_nxt = 1'b1;
         default: rd_en_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_all) begin
         state        <= RDY_REQ;
         prev_rdy     <= 1'b1;
         count_reg    <= 32'd0;
         rem          <= 32'd0;
         bit_cnt      <= 5'd0;
         sum          <= 18'd0;
         win          <= '{default: 16'd0};
         dist_cm      <= 16'd0;
         dist_avg_cm  <= 16'd0;
         dist_valid   <= 1'b0;
         out_of_range <= 1'b0;
         near         <= 1'b0;
         us_addr      <= 1'b0;
         us_read_en   <= 1'b0;
      end else begin
         state      <= state_nxt;
         us_addr    <= addr_nxt;
         us_read_en <= rd_en_nxt;
         dist_valid <= (state == UPDATE);
         if (state == RDY_CHK)
            prev_rdy <= rdy;
         if (state == CNT_CAP) begin
            count_reg <= us_read_data;
            rem       <= 32'd0;
            bit_cnt   <= 5'd0;
         end
         if (state == DIV) begin
            bit_cnt   <= bit_cnt + 5'd1;
            rem       <= rem_ge ? rem_sub : rem_sh[31:0];
            count_reg <= {count_reg[30:0], rem_ge};
         end
         if (state == UPDATE) begin
            dist_cm      <= new_cm;
            out_of_range <= over;
            win[0]       <= new_cm;
            win[1]       <= win[0];
            win[2]       <= win[1];
            win[3]       <= win[2];
            sum          <= sum_nxt;
            dist_avg_cm  <= avg_nxt;
            if (avg_nxt < NEAR_LO)
               near <= 1'b1;
            else if (avg_nxt >= NEAR_HI)
               near <= 1'b0;
         end
      end
   end

endmodule
